// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-port mem between loader (LD), data path
// (DT) and fetcher (FE) with a one-access-at-a-time grant handshake.
//
// Ports:
//   clk, reset (async, active high), hold (blocks new grants in IDLE)
//   ld_*/dt_*/fe_* : req, we, addr, wdata in; gnt, rvalid pulses out
//   rdata          : shared read data, qualified by the *_rvalid pulses
//   mem_we/mem_addr/mem_din out, mem_dout in : registered memory port
//   busy (state != IDLE), owner (0 none, 1 LD, 2 DT, 3 FE)
module mem_arbiter #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  hold,
   input  logic                  ld_req,
   input  logic                  ld_we,
   input  logic [ADDR_WIDTH-1:0] ld_addr,
   input  logic [DATA_WIDTH-1:0] ld_wdata,
   output logic                  ld_gnt,
   output logic                  ld_rvalid,
   input  logic                  dt_req,
   input  logic                  dt_we,
   input  logic [ADDR_WIDTH-1:0] dt_addr,
   input  logic [DATA_WIDTH-1:0] dt_wdata,
   output logic                  dt_gnt,
   output logic                  dt_rvalid,
   input  logic                  fe_req,
   input  logic [ADDR_WIDTH-1:0] fe_addr,
   output logic                  fe_gnt,
   output logic                  fe_rvalid,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_din,
   input  logic [DATA_WIDTH-1:0] mem_dout,
   output logic                  busy,
   output logic [1:0]            owner
);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RDWAIT
   } state_t;

   localparam logic [1:0] OWN_NONE = 2'd0;
   localparam logic [1:0] OWN_LD   = 2'd1;
   localparam logic [1:0] OWN_DT   = 2'd2;
   localparam logic [1:0] OWN_FE   = 2'd3;

   state_t state_q, state_d;

   logic [1:0]            win;
   logic                  win_we;
   logic [ADDR_WIDTH-1:0] win_addr;
   logic [DATA_WIDTH-1:0] win_wdata;
   logic                  we_q;
   // 1 when FE held the last DT/FE grant, so DT wins the next tie
   logic                  rr_fe_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      win     = OWN_NONE;
      unique case (state_q)
         IDLE: begin
            if (!hold) begin
               if (ld_req)
                  win = OWN_LD;
               else if (dt_req && fe_req)
                  win = rr_fe_q ? OWN_DT : OWN_FE;
               else if (dt_req)
                  win = OWN_DT;
               else if (fe_req)
                  win = OWN_FE;
               if (win != OWN_NONE)
                  state_d = ACCESS;
            end
         end
         ACCESS:  state_d = we_q ? IDLE : RDWAIT;
         RDWAIT:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Fetch never writes; its wdata slot keeps mem_din unchanged.
   always_comb begin
      win_we    = 1'b0;
      win_addr  = mem_addr;
      win_wdata = mem_din;
      unique case (win)
         OWN_LD: begin
            win_we    = ld_we;
            win_addr  = ld_addr;
            win_wdata = ld_wdata;
         end
         OWN_DT: begin
            win_we    = dt_we;
            win_addr  = dt_addr;
            win_wdata = dt_wdata;
         end
         OWN_FE:  win_addr = fe_addr;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ld_gnt    <= 1'b0;
         dt_gnt    <= 1'b0;
         fe_gnt    <= 1'b0;
         ld_rvalid <= 1'b0;
         dt_rvalid <= 1'b0;
         fe_rvalid <= 1'b0;
         rdata     <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_din   <= '0;
         we_q      <= 1'b0;
         owner     <= OWN_NONE;
         rr_fe_q   <= 1'b1;
      end else begin
         ld_gnt    <= (win == OWN_LD);
         dt_gnt    <= (win == OWN_DT);
         fe_gnt    <= (win == OWN_FE);
         ld_rvalid <= 1'b0;
         dt_rvalid <= 1'b0;
         fe_rvalid <= 1'b0;
         // mem_we is high only in the ACCESS cycle of a write
         mem_we    <= 1'b0;
         if (win != OWN_NONE) begin
            mem_addr <= win_addr;
            mem_din  <= win_wdata;
            we_q     <= win_we;
            mem_we   <= win_we;
            owner    <= win;
            if (win == OWN_DT) rr_fe_q <= 1'b0;
            if (win == OWN_FE) rr_fe_q <= 1'b1;
         end
         if (state_q == ACCESS && we_q)
            owner <= OWN_NONE;
         if (state_q == RDWAIT) begin
            rdata     <= mem_dout;
            ld_rvalid <= (owner == OWN_LD);
            dt_rvalid <= (owner == OWN_DT);
            fe_rvalid <= (owner == OWN_FE);
            owner     <= OWN_NONE;
         end
      end
   end

   assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a behavioural
// single-port memory (read data one clock after the address is sampled).
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        hold = 1'b0;
   logic        ld_req = 1'b0, ld_we = 1'b0;
   logic [15:0] ld_addr = '0;
   logic [7:0]  ld_wdata = '0;
   logic        ld_gnt, ld_rvalid;
   logic        dt_req = 1'b0, dt_we = 1'b0;
   logic [15:0] dt_addr = '0;
   logic [7:0]  dt_wdata = '0;
   logic        dt_gnt, dt_rvalid;
   logic        fe_req = 1'b0;
   logic [15:0] fe_addr = '0;
   logic        fe_gnt, fe_rvalid;
   logic [7:0]  rdata;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [7:0]  mem_din;
   logic [7:0]  mem_dout = '0;
   logic        busy;
   logic [1:0]  owner;

   int total = 0;
   int bad = 0;

   logic [7:0] mem [0:65535];

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_din;
      mem_dout <= mem[mem_addr];
   end

   mem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) dut (
      .clk(clk), .reset(reset), .hold(hold),
      .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr),
      .ld_wdata(ld_wdata), .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid),
      .dt_req(dt_req), .dt_we(dt_we), .dt_addr(dt_addr),
      .dt_wdata(dt_wdata), .dt_gnt(dt_gnt), .dt_rvalid(dt_rvalid),
      .fe_req(fe_req), .fe_addr(fe_addr),
      .fe_gnt(fe_gnt), .fe_rvalid(fe_rvalid),
      .rdata(rdata), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_din(mem_din), .mem_dout(mem_dout),
      .busy(busy), .owner(owner)
   );

   function automatic logic [41:0] outs();
      return {ld_gnt, ld_rvalid, dt_gnt, dt_rvalid, fe_gnt,
              fe_rvalid, rdata, mem_we, mem_addr, mem_din,
              busy, owner};
   endfunction

   // steps negedges until some gnt shows; ok=0 if none within budget
   task automatic wait_gnt(output logic [1:0] who, output bit ok);
      who = 2'd0;
      ok  = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (ld_gnt || dt_gnt || fe_gnt) begin
            who = ld_gnt ? 2'd1 : (dt_gnt ? 2'd2 : 2'd3);
            ok  = 1'b1;
            break;
         end
      end
   endtask

   task automatic reset_dut;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      total++;
      if (outs() !== '0) begin
         bad++;
         $display("FAIL reset_outs got=%h want=0", outs());
      end
      reset = 1'b0;
   endtask

   task automatic test_write;
      @(negedge clk);
      dt_req = 1'b1; dt_we = 1'b1;
      dt_addr = 16'h0010; dt_wdata = 8'hA5;
      @(negedge clk);
      total++;
      if ({dt_gnt, mem_we, mem_addr, mem_din, owner, busy}
          !== {1'b1, 1'b1, 16'h0010, 8'hA5, 2'd2, 1'b1}) begin
         bad++;
         $display("FAIL wr_access got=%b/%b/%h/%h/%0d/%b want=1/1/0010/a5/2/1",
                  dt_gnt, mem_we, mem_addr, mem_din, owner, busy);
      end
      dt_req = 1'b0; dt_we = 1'b0;
      @(negedge clk);
      total++;
      if ({dt_gnt, mem_we, busy, owner} !== 5'b0) begin
         bad++;
         $display("FAIL wr_done gnt=%b we=%b busy=%b owner=%0d want 0",
                  dt_gnt, mem_we, busy, owner);
      end
      total++;
      if ({ld_rvalid, dt_rvalid, fe_rvalid} !== 3'b0) begin
         bad++;
         $display("FAIL wr_rvalid got=%b want=000",
                  {ld_rvalid, dt_rvalid, fe_rvalid});
      end
      total++;
      if (mem[16'h0010] !== 8'hA5) begin
         bad++;
         $display("FAIL wr_mem got=%h want=a5", mem[16'h0010]);
      end
   endtask

   task automatic test_read;
      dt_req = 1'b1; dt_we = 1'b0; dt_addr = 16'h0010;
      @(negedge clk);
      total++;
      if ({dt_gnt, mem_we, mem_addr} !== {1'b1, 1'b0, 16'h0010}) begin
         bad++;
         $display("FAIL rd_gnt got=%b/%b/%h want=1/0/0010",
                  dt_gnt, mem_we, mem_addr);
      end
      dt_req = 1'b0;
      @(negedge clk);
      total++;
      if ({busy, dt_rvalid, mem_we} !== 3'b100) begin
         bad++;
         $display("FAIL rd_wait got=%b want=100",
                  {busy, dt_rvalid, mem_we});
      end
      @(negedge clk);
      total++;
      if ({dt_rvalid, ld_rvalid, fe_rvalid, rdata, busy}
          !== {3'b100, 8'hA5, 1'b0}) begin
         bad++;
         $display("FAIL rd_data rv=%b%b%b rdata=%h busy=%b want 100/a5/0",
                  dt_rvalid, ld_rvalid, fe_rvalid, rdata, busy);
      end
      @(negedge clk);
      total++;
      if ({dt_rvalid, rdata} !== {1'b0, 8'hA5}) begin
         bad++;
         $display("FAIL rd_hold rv=%b rdata=%h want 0/a5",
                  dt_rvalid, rdata);
      end
   endtask

   task automatic test_round_robin;
      logic [1:0] who;
      logic [1:0] exp;
      bit ok;
      reset_dut();
      dt_req = 1'b1; dt_we = 1'b0; dt_addr = 16'h0010;
      fe_req = 1'b1; fe_addr = 16'h0020;
      for (int k = 0; k < 4; k++) begin
         exp = (k % 2 == 0) ? 2'd2 : 2'd3;
         wait_gnt(who, ok);
         total++;
         if (!ok || who !== exp || owner !== exp) begin
            bad++;
            $display("FAIL rr_grant%0d ok=%0d who=%0d owner=%0d want %0d",
                     k, ok, who, owner, exp);
         end
      end
      dt_req = 1'b0; fe_req = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_hold;
      logic [1:0] who;
      bit ok;
      hold = 1'b1;
      ld_req = 1'b1; ld_we = 1'b1;
      ld_addr = 16'h0030; ld_wdata = 8'h11;
      dt_req = 1'b1; dt_we = 1'b0; dt_addr = 16'h0010;
      fe_req = 1'b1; fe_addr = 16'h0020;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         total++;
         if ({ld_gnt, dt_gnt, fe_gnt, busy} !== 4'b0) begin
            bad++;
            $display("FAIL hold_block%0d gnt=%b%b%b busy=%b want 0",
                     c, ld_gnt, dt_gnt, fe_gnt, busy);
         end
      end
      hold = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         wait_gnt(who, ok);
         total++;
         if (!ok || who !== 2'(k)) begin
            bad++;
            $display("FAIL hold_order%0d ok=%0d who=%0d want %0d",
                     k, ok, who, k);
         end
         if (who == 2'd1) ld_req = 1'b0;
         if (who == 2'd2) dt_req = 1'b0;
         if (who == 2'd3) fe_req = 1'b0;
      end
      ld_req = 1'b0; dt_req = 1'b0; fe_req = 1'b0; ld_we = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_burst;
      logic [1:0] who;
      bit ok;
      bit got;
      for (int i = 0; i < 16; i++) begin
         ld_req = 1'b1; ld_we = 1'b1;
         ld_addr = 16'(i); ld_wdata = 8'(i);
         wait_gnt(who, ok);
         total++;
         if (!ok || {who, mem_we, mem_addr, mem_din}
             !== {2'd1, 1'b1, 16'(i), 8'(i)}) begin
            bad++;
            $display("FAIL ld_wr%0d who=%0d we=%b a=%h d=%h",
                     i, who, mem_we, mem_addr, mem_din);
         end
      end
      ld_req = 1'b0; ld_we = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 16; i++) begin
         fe_req = 1'b1; fe_addr = 16'(i);
         wait_gnt(who, ok);
         fe_req = 1'b0;
         got = 1'b0;
         for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            if (fe_rvalid) begin
               got = 1'b1;
               break;
            end
         end
         total++;
         if (!ok || who !== 2'd3 || !got || rdata !== 8'(i)
             || ld_rvalid || dt_rvalid) begin
            bad++;
            $display("FAIL fe_rd%0d gnt=%0d/%0d rv=%0d rdata=%h want %h",
                     i, ok, who, got, rdata, 8'(i));
         end
      end
   endtask

   task automatic test_reset_mid;
      logic [1:0] who;
      bit ok;
      bit got;
      bit stray;
      dt_req = 1'b1; dt_we = 1'b1;
      dt_addr = 16'h0040; dt_wdata = 8'h77;
      @(negedge clk);
      dt_req = 1'b0; dt_we = 1'b0;
      total++;
      if (mem_we !== 1'b1) begin
         bad++;
         $display("FAIL rst_pre_we got=%b want=1", mem_we);
      end
      #1 reset = 1'b1;
      #1;
      total++;
      if (outs() !== '0) begin
         bad++;
         $display("FAIL rst_access_outs got=%h want=0", outs());
      end
      @(negedge clk);
      reset = 1'b0;
      total++;
      if (mem[16'h0040] === 8'h77) begin
         bad++;
         $display("FAIL rst_write_dropped got=%h want not 77",
                  mem[16'h0040]);
      end
      dt_req = 1'b1; dt_addr = 16'h0010;
      @(negedge clk);
      dt_req = 1'b0;
      @(negedge clk);
      total++;
      if ({busy, owner} !== 3'b110) begin
         bad++;
         $display("FAIL rst_rdwait busy=%b owner=%0d want 1/2",
                  busy, owner);
      end
      #1 reset = 1'b1;
      #1;
      total++;
      if (outs() !== '0) begin
         bad++;
         $display("FAIL rst_rdwait_outs got=%h want=0", outs());
      end
      @(negedge clk);
      total++;
      if (outs() !== '0) begin
         bad++;
         $display("FAIL rst_held_outs got=%h want=0", outs());
      end
      reset = 1'b0;
      fe_req = 1'b1; fe_addr = 16'h0005;
      wait_gnt(who, ok);
      fe_req = 1'b0;
      got = 1'b0;
      stray = dt_rvalid;
      for (int j = 0; j < 6; j++) begin
         @(negedge clk);
         if (dt_rvalid) stray = 1'b1;
         if (fe_rvalid) begin
            got = 1'b1;
            break;
         end
      end
      total++;
      if (!ok || who !== 2'd3 || !got || rdata !== 8'h05 || stray) begin
         bad++;
         $display("FAIL rst_fe_read gnt=%0d/%0d rv=%0d rdata=%h dt_rv=%0d want 05",
                  ok, who, got, rdata, stray);
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_round_robin();
      test_hold();
      test_burst();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
